// File: rtl/traffic_gen_checker_if.sv
// traffic_gen_checker_if: stimulus and response bundle between the generator/checker and the DUT pair
interface traffic_gen_checker_if #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_CH = 2
);
  logic wr_enable;
  logic [DATA_WIDTH-1:0] data_in;
  logic [NUM_CH-1:0] pop;
  logic init;
  logic [3:0] umbral_MFs_o, umbral_VCs_o, umbral_Ds_o;
  logic [NUM_CH*DATA_WIDTH-1:0] data_out_cond, data_out_synth;
  logic [NUM_CH-1:0] empty_cond, empty_synth, error_cond, error_synth;
  logic [2:0] status_cond, status_synth;
  modport master (
    output wr_enable, data_in, pop, init, umbral_MFs_o, umbral_VCs_o, umbral_Ds_o,
    input data_out_cond, data_out_synth, empty_cond, empty_synth, error_cond, error_synth,
    status_cond, status_synth
  );
  modport slave (
    input wr_enable, data_in, pop, init, umbral_MFs_o, umbral_VCs_o, umbral_Ds_o,
    output data_out_cond, data_out_synth, empty_cond, empty_synth, error_cond, error_synth,
    status_cond, status_synth
  );
endinterface

// File: rtl/traffic_gen_checker.sv
// traffic_gen_checker: drives a write/drain run into a DUT pair and compares cond vs synth responses.
// Optional ERROR_INJECT_EN adds inject_err to force an all-ones word during STREAM.
module traffic_gen_checker #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_CH = 2,
  parameter int WORDS = 39,
  parameter int BASE = 0,
  parameter int CONFIG_CYCLES = 2,
  parameter int DRAIN_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  input logic start,
  input logic [3:0] umbral_MFs,
  input logic [3:0] umbral_VCs,
  input logic [3:0] umbral_Ds,
`ifdef ERROR_INJECT_EN
  input logic inject_err,
`endif
  traffic_gen_checker_if.master bus,
  output logic busy,
  output logic done,
  output logic mismatch,
  output logic [7:0] mismatch_count,
  output logic [15:0] first_mismatch_cyc
);
  typedef enum logic [2:0] {IDLE, CONFIG, INIT, STREAM, DRAIN, DONE} state_t;
  localparam logic [15:0] CFG_LAST = 16'(CONFIG_CYCLES - 1);
  localparam logic [15:0] DRN_LAST = 16'(DRAIN_CYCLES - 1);
  localparam logic [15:0] WORD_LAST = 16'(WORDS - 1);
  state_t state;
  logic [15:0] cnt, k, run_cyc;
  logic [DATA_WIDTH-1:0] data_q;
  logic diff;
  assign diff = |{bus.data_out_cond ^ bus.data_out_synth, bus.empty_cond ^ bus.empty_synth,
                  bus.error_cond ^ bus.error_synth, bus.status_cond ^ bus.status_synth};
`ifdef ERROR_INJECT_EN
  assign bus.data_in = (bus.wr_enable && inject_err) ? '1 : data_q;
`else
  assign bus.data_in = data_q;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      k <= '0;
      run_cyc <= '0;
      data_q <= '0;
      bus.wr_enable <= 1'b0;
      bus.pop <= '0;
      bus.init <= 1'b0;
      bus.umbral_MFs_o <= '0;
      bus.umbral_VCs_o <= '0;
      bus.umbral_Ds_o <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      mismatch <= 1'b0;
      mismatch_count <= '0;
      first_mismatch_cyc <= '0;
    end else begin
      // busy marks the compare window, CONFIG through DRAIN
      if (busy) begin
        run_cyc <= run_cyc + 16'(run_cyc != 16'hFFFF);
        if (diff) begin
          mismatch_count <= mismatch_count + 8'(mismatch_count != 8'hFF);
          mismatch <= 1'b1;
          if (!mismatch) first_mismatch_cyc <= run_cyc;
        end
      end
      case (state)
        IDLE, DONE: if (start) begin
          state <= CONFIG;
          bus.umbral_MFs_o <= umbral_MFs;
          bus.umbral_VCs_o <= umbral_VCs;
          bus.umbral_Ds_o <= umbral_Ds;
          busy <= 1'b1;
          done <= 1'b0;
          cnt <= '0;
          k <= '0;
          run_cyc <= '0;
          data_q <= DATA_WIDTH'(BASE);
          mismatch <= 1'b0;
          mismatch_count <= '0;
          first_mismatch_cyc <= '0;
        end
        CONFIG: if (cnt == CFG_LAST) begin
          state <= INIT;
          bus.init <= 1'b1;
          cnt <= '0;
        end else cnt <= cnt + 16'd1;
        INIT: if (WORDS == 0) begin
          state <= DRAIN;
          bus.pop <= '1;
        end else begin
          state <= STREAM;
          bus.wr_enable <= 1'b1;
        end
        STREAM: begin
          k <= k + 16'd1;
          data_q <= data_q + DATA_WIDTH'(1);
          if (k == WORD_LAST) begin
            state <= DRAIN;
            bus.wr_enable <= 1'b0;
            bus.pop <= '1;
          end
        end
        DRAIN: if (cnt == DRN_LAST) begin
          state <= DONE;
          bus.pop <= '0;
          bus.init <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
        end else cnt <= cnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_traffic_gen_checker.sv
// tb_traffic_gen_checker: scoreboard bench; stimulus queues expected events, monitors pop and compare.
module tb_traffic_gen_checker;
  localparam int DW = 6;
  localparam int NC = 2;
  typedef enum {EV_INIT, EV_WR, EV_POP, EV_DONE} ev_t;
  typedef struct {ev_t kind; int value; int cycle;} exp_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, start2 = 1'b0;
  logic [3:0] mfs = '0, vcs = '0, ds = '0;
`ifdef ERROR_INJECT_EN
  logic inject_err = 1'b0;
`endif
  logic busy, done, mismatch, busy2, done2, mismatch2;
  logic [7:0] mcount, mcount2;
  logic [15:0] first, first2;
  int cyc = 0, passed = 0, total = 0;
  exp_t q[$];
  int q2[$], r2[$];
  logic prev_init = 1'b0, prev_done = 1'b0, prev_done2 = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  traffic_gen_checker_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus();
  traffic_gen_checker_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus2();
  traffic_gen_checker #(.DATA_WIDTH(DW), .NUM_CH(NC), .WORDS(4), .BASE(5), .CONFIG_CYCLES(2), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .umbral_MFs(mfs), .umbral_VCs(vcs), .umbral_Ds(ds),
`ifdef ERROR_INJECT_EN
    .inject_err(inject_err),
`endif
    .bus(bus), .busy(busy), .done(done), .mismatch(mismatch),
    .mismatch_count(mcount), .first_mismatch_cyc(first)
  );
  traffic_gen_checker #(.DATA_WIDTH(DW), .NUM_CH(NC), .WORDS(300), .BASE(62), .CONFIG_CYCLES(2), .DRAIN_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .umbral_MFs(mfs), .umbral_VCs(vcs), .umbral_Ds(ds),
`ifdef ERROR_INJECT_EN
    .inject_err(1'b0),
`endif
    .bus(bus2), .busy(busy2), .done(done2), .mismatch(mismatch2),
    .mismatch_count(mcount2), .first_mismatch_cyc(first2)
  );
  function automatic int res(int m, int c, int f);
    return (m << 24) | (c << 16) | f;
  endfunction
  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask
  task automatic push(ev_t k, int v, int c);
    exp_t e;
    e.kind = k;
    e.value = v;
    e.cycle = c;
    q.push_back(e);
  endtask
  task automatic push_run(int n, int thr, int d[4], int r);
    push(EV_INIT, thr, n + 3);
    for (int i = 0; i < 4; i++) push(EV_WR, d[i], n + 4 + i);
    for (int i = 0; i < 3; i++) push(EV_POP, 3, n + 8 + i);
    push(EV_DONE, r, n + 11);
  endtask
  task automatic expect_ev(ev_t k, int v);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      $display("FAIL event: got unexpected %s value %0d at cycle %0d", k.name(), v, cyc);
    end else begin
      e = q.pop_front();
      if (k == e.kind && v == e.value && cyc == e.cycle) passed++;
      else $display("FAIL event: got %s value %0d cycle %0d, expected %s value %0d cycle %0d",
                    k.name(), v, cyc, e.kind.name(), e.value, e.cycle);
    end
  endtask
  always @(negedge clk) begin
    if (bus.init && !prev_init) expect_ev(EV_INIT, int'({bus.umbral_MFs_o, bus.umbral_VCs_o, bus.umbral_Ds_o}));
    if (bus.wr_enable) expect_ev(EV_WR, int'(bus.data_in));
    if (bus.pop != '0) expect_ev(EV_POP, int'(bus.pop));
    if (done && !prev_done) expect_ev(EV_DONE, int'({mismatch, mcount, first}));
    prev_init = bus.init;
    prev_done = done;
  end
  always @(negedge clk) begin
    if (bus2.wr_enable) begin
      if (q2.size() == 0) begin
        total++;
        $display("FAIL wrap data_in: got unexpected word %0d at cycle %0d", bus2.data_in, cyc);
      end else check("wrap data_in", int'(bus2.data_in), q2.pop_front());
    end
    if (done2 && !prev_done2) begin
      if (r2.size() == 0) begin
        total++;
        $display("FAIL saturation result: got unexpected done at cycle %0d", cyc);
      end else check("saturation result", int'({mismatch2, mcount2, first2}), r2.pop_front());
    end
    prev_done2 = done2;
  end
  task automatic check_zero(string tag);
    check({tag, " busy/done/mismatch"}, int'({busy, done, mismatch}), 0);
    check({tag, " counts"}, int'({mcount, first}), 0);
    check({tag, " strobes"}, int'({bus.wr_enable, bus.init, bus.pop}), 0);
    check({tag, " data_in"}, int'(bus.data_in), 0);
    check({tag, " thresholds"}, int'({bus.umbral_MFs_o, bus.umbral_VCs_o, bus.umbral_Ds_o}), 0);
  endtask
  task automatic do_start(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, output int n);
    @(negedge clk);
    mfs = a;
    vcs = b;
    ds = c;
    start = 1'b1;
    n = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(int budget);
    int i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (!done) begin
      total++;
      $display("FAIL done timeout: got done=0 expected done=1 within %0d cycles", budget);
    end
    @(negedge clk);
  endtask
  initial begin
    int n;
    int i;
    bus.data_out_cond = 12'hA5C;
    bus.data_out_synth = 12'hA5C;
    bus.empty_cond = '0;
    bus.empty_synth = '0;
    bus.error_cond = '0;
    bus.error_synth = '0;
    bus.status_cond = '0;
    bus.status_synth = '0;
    bus2.data_out_cond = '0;
    bus2.data_out_synth = '0;
    bus2.empty_cond = '0;
    bus2.empty_synth = '0;
    bus2.error_cond = '0;
    bus2.error_synth = '0;
    bus2.status_cond = 3'b000;
    bus2.status_synth = 3'b001;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    do_start(4'h1, 4'h2, 4'h3, n);
    push_run(n, 'h123, '{5, 6, 7, 8}, res(0, 0, 0));
    wait_done(20);
    do_start(4'h4, 4'h5, 4'h6, n);
    push_run(n, 'h456, '{5, 6, 7, 8}, res(1, 1, 7));
    repeat (7) @(negedge clk);
    bus.data_out_synth = bus.data_out_cond ^ 12'd1;
    @(negedge clk);
    bus.data_out_synth = bus.data_out_cond;
    wait_done(20);
    do_start(4'h7, 4'h8, 4'h9, n);
    push(EV_INIT, 'h789, n + 3);
    for (int j = 0; j < 3; j++) push(EV_WR, 5 + j, n + 4 + j);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("mid-stream reset");
    check("queue drained at reset", q.size(), 0);
    reset = 1'b0;
    do_start(4'hA, 4'hB, 4'hC, n);
    push_run(n, 'hABC, '{5, 6, 7, 8}, res(0, 0, 0));
    wait_done(20);
`ifdef ERROR_INJECT_EN
    do_start(4'h1, 4'h1, 4'h1, n);
    push_run(n, 'h111, '{5, 63, 7, 8}, res(0, 0, 0));
    repeat (4) @(negedge clk);
    inject_err = 1'b1;
    @(negedge clk);
    inject_err = 1'b0;
    wait_done(20);
`endif
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int j = 0; j < 300; j++) q2.push_back((62 + j) % 64);
    r2.push_back(res(1, 255, 0));
    i = 0;
    while (!done2 && i < 400) begin
      @(negedge clk);
      i++;
    end
    check("long run done", int'(done2), 1);
    @(negedge clk);
    check("scoreboard empty", q.size() + q2.size() + r2.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 time units");
    $fatal(1);
  end
endmodule

// File: doc/traffic_gen_checker.md
TRAFFIC_GEN_CHECKER -- requirements
Module: traffic_gen_checker

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 6, word width (4..16).
- NUM_CH, 2, output channel count (1..8).
- WORDS, 39, words per stream.
- BASE, 0, first data value.
- CONFIG_CYCLES, 2, cycles thresholds are held before init.
- DRAIN_CYCLES, 10, pop cycles after the stream.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all logic rises on posedge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, begin run.
- umbral_MFs/umbral_VCs/umbral_Ds, in, 4 each, threshold values to apply.
- wr_enable, out, 1, DUT write strobe.
- data_in, out, DATA_WIDTH, DUT write word.
- pop, out, NUM_CH, per-channel pop.
- init, out, 1, DUT init.
- umbral_MFs_o/umbral_VCs_o/umbral_Ds_o, out, 4 each, thresholds driven to DUT.
- data_out_cond/data_out_synth, in, NUM_CH*DATA_WIDTH, behavioural/synthesised DUT data.
- empty_cond/empty_synth, error_cond/error_synth, in, NUM_CH each, DUT flags.
- status_cond/status_synth, in, 3, {error_out, active_out, idle_out}.
- busy, done, mismatch, out, 1 each.
- mismatch_count, out, 8, saturating mismatch count.
- first_mismatch_cyc, out, 16, run cycle of first mismatch.

Function
REQ-003 FSM states: IDLE, CONFIG, INIT, STREAM, DRAIN, DONE; state register updates on posedge clk.
REQ-004 IDLE or DONE with start=1 -> CONFIG next cycle; start is ignored in all other states.
REQ-005 CONFIG: umbral_*_o = captured inputs; stays exactly CONFIG_CYCLES cycles, then -> INIT.
REQ-006 Threshold inputs are captured on the cycle start is accepted; they are held on the _o ports from CONFIG until the next accepted start.
REQ-007 INIT: init=1 for one cycle; init stays 1 through STREAM and DRAIN; -> STREAM (or -> DRAIN if WORDS=0).
REQ-008 STREAM: wr_enable=1; data_in = (BASE+k) mod 2^DATA_WIDTH for word k=0..WORDS-1, one word per cycle; wraps silently; -> DRAIN after word WORDS-1.
REQ-009 DRAIN: wr_enable=0, pop=all ones, exactly DRAIN_CYCLES cycles; -> DONE.
REQ-010 DONE: done=1, all strobes 0, init=0; results held until next start.
REQ-011 busy=1 in CONFIG, INIT, STREAM and DRAIN; otherwise 0.
REQ-012 Run cycle counter (16-bit): 0 in the first CONFIG cycle, +1 per cycle until DONE; saturates at 0xFFFF.
REQ-013 Compare window runs from CONFIG through DRAIN.
- A mismatch cycle is any bit difference between cond and synth on data_out, empty, error or status.
REQ-014 On each mismatch cycle:
- mismatch_count +1, saturating at 255.
- mismatch set sticky.
- first_mismatch_cyc = run counter, captured only while mismatch was 0.
REQ-015 An accepted start clears mismatch, mismatch_count, first_mismatch_cyc, the run counter and k.

Reset
REQ-016 reset=1 at a posedge forces IDLE from any state, including mid-STREAM.
REQ-017 Under reset, all outputs are 0 and all counters/flags are cleared; reset has priority over start.

Configuration
REQ-018 ERROR_INJECT_EN defined:
- Adds input inject_err (1 bit).
- In STREAM with inject_err=1, data_in = all ones for that cycle; k still advances.
REQ-019 ERROR_INJECT_EN undefined: no inject_err port; data_in strictly follows REQ-008.

Verification
REQ-020 Defaults except WORDS=4, BASE=5, DRAIN_CYCLES=3. Pulse start at cycle n ->
- CONFIG n+1..n+2; INIT n+3.
- data_in 5,6,7,8 with wr_enable=1 at n+4..n+7.
- pop=2'b11 at n+8..n+10; done=1 at n+11.
REQ-021 BASE=62, WORDS=4 -> data_in 62,63,0,1.
REQ-022 synth data differs only at run cycle 7 -> mismatch=1, mismatch_count=1, first_mismatch_cyc=7.
REQ-023 Constant status mismatch for 300 cycles -> mismatch_count=255 (saturated).
REQ-024 reset=1 at word 2 -> next cycle IDLE, all outputs 0; a new start restarts at data_in=BASE.
REQ-025 ERROR_INJECT_EN defined, inject_err=1 at word 1 (BASE=5) -> data_in 5,63,7,8.
